// File: rtl/operand_pkg.sv
// ---------------------------------------------------------------------------
// operand_pkg
// Shared constants and types for the operand-fetch stage and the ALU.
//   DEF_DATA_W : default register/operand width
//   DEF_ADDR_W : default register address width (2**DEF_ADDR_W entries)
//   DEF_HI_REG : register index that receives the ALU upper result
//   ZERO_REG   : hard-wired zero register index
//   opcode_t   : 4-bit ALU opcode
// ---------------------------------------------------------------------------
package operand_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_HI_REG = 15;
  localparam int ZERO_REG   = 0;
  localparam int OP_W       = 4;

  typedef logic [OP_W-1:0] opcode_t;

endpackage

// File: rtl/operand_regfile_if.sv
// ---------------------------------------------------------------------------
// operand_regfile_if
// Bus between the operand-fetch stage and its neighbours.
//   Read side  : rd_valid, stall, rs_addr, rt_addr, op_in
//   ALU side   : dat1, dat2, op, op_valid (registered operands)
//   Writeback  : wb_en, wb_addr, wb_lower, wb_upper_en, wb_upper, wb_zero
//   Status     : zero_flag
// Modports: master drives requests/writeback, slave is the register file.
// ---------------------------------------------------------------------------
interface operand_regfile_if
  import operand_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              rd_valid;
  logic              stall;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  opcode_t           op_in;
  logic [DATA_W-1:0] dat1;
  logic [DATA_W-1:0] dat2;
  opcode_t           op;
  logic              op_valid;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_lower;
  logic              wb_upper_en;
  logic [DATA_W-1:0] wb_upper;
  logic              wb_zero;
  logic              zero_flag;

  modport master (
    output rd_valid, stall, rs_addr, rt_addr, op_in,
    output wb_en, wb_addr, wb_lower, wb_upper_en, wb_upper, wb_zero,
    input  dat1, dat2, op, op_valid, zero_flag
  );

  modport slave (
    input  rd_valid, stall, rs_addr, rt_addr, op_in,
    input  wb_en, wb_addr, wb_lower, wb_upper_en, wb_upper, wb_zero,
    output dat1, dat2, op, op_valid, zero_flag
  );

endinterface

// File: rtl/operand_regfile_core.sv
// ---------------------------------------------------------------------------
// regfile_core
// Register storage with write priority and combinational read muxes.
//   clk, rst_n            : clock, async active-low reset
//   wb_en/wb_addr/wb_lower: lower-result write
//   wb_upper_en/wb_upper  : upper-result write into HI_REG (wins on conflict)
//   wb_zero, zero_flag    : sticky zero status, loaded whenever wb_en=1
//   rs_addr/rd1, rt_addr/rd2 : read ports; register 0 always reads zero
// ---------------------------------------------------------------------------
module regfile_core
  import operand_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int HI_REG = DEF_HI_REG
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_lower,
  input  logic              wb_upper_en,
  input  logic [DATA_W-1:0] wb_upper,
  input  logic              wb_zero,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              zero_flag
);

  localparam int                NREG      = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] HI_ADDR   = ADDR_W'(HI_REG);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem_r [NREG];
  logic              zero_flag_r;
  logic              lo_we_s;
  logic              hi_we_s;
  logic [DATA_W-1:0] rd1_s;
  logic [DATA_W-1:0] rd2_s;

  // Write enables: R0 writes are dropped, and the upper result owns HI_REG.
  always_comb begin
    lo_we_s = 1'b0;
    hi_we_s = wb_upper_en;
    if (wb_en && (wb_addr != ZERO_ADDR) && !(wb_upper_en && (wb_addr == HI_ADDR))) begin
      lo_we_s = 1'b1;
    end else begin
      lo_we_s = 1'b0;
    end
  end

  // Storage array and sticky zero flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        mem_r[i] <= {DATA_W{1'b0}};
      end
      zero_flag_r <= 1'b0;
    end else begin
      if (lo_we_s) begin
        mem_r[wb_addr] <= wb_lower;
      end
      if (hi_we_s) begin
        mem_r[HI_ADDR] <= wb_upper;
      end
      // zero status follows wb_en even when the data write itself is dropped
      if (wb_en) begin
        zero_flag_r <= wb_zero;
      end
    end
  end

  // Read muxes with the hard-wired zero register.
  always_comb begin
    rd1_s = {DATA_W{1'b0}};
    rd2_s = {DATA_W{1'b0}};
    if (rs_addr != ZERO_ADDR) begin
      rd1_s = mem_r[rs_addr];
    end else begin
      rd1_s = {DATA_W{1'b0}};
    end
    if (rt_addr != ZERO_ADDR) begin
      rd2_s = mem_r[rt_addr];
    end else begin
      rd2_s = {DATA_W{1'b0}};
    end
  end

  assign rd1       = rd1_s;
  assign rd2       = rd2_s;
  assign zero_flag = zero_flag_r;

endmodule

// File: rtl/operand_regfile.sv
// ---------------------------------------------------------------------------
// operand_regfile
// Operand-fetch stage feeding the ALU: register file plus a stallable
// operand pipeline register (1-cycle read latency).
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : operand_regfile_if.slave (read request, operands, writeback,
//           zero_flag)
// Optional feature macro OPERAND_BYPASS_EN: when defined, a read of a
// register written on the same edge captures the incoming write value
// (write-first); otherwise the pre-write contents are captured (read-first).
// ---------------------------------------------------------------------------
module operand_regfile
  import operand_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int HI_REG = DEF_HI_REG
) (
  input  logic                clk,
  input  logic                rst_n,
  operand_regfile_if.slave    bus
);

  logic [DATA_W-1:0] rd1_s;
  logic [DATA_W-1:0] rd2_s;
  logic [DATA_W-1:0] opnd1_s;
  logic [DATA_W-1:0] opnd2_s;
  logic [DATA_W-1:0] dat1_r;
  logic [DATA_W-1:0] dat2_r;
  opcode_t           op_r;
  logic              op_valid_r;
  logic              zero_flag_s;

  regfile_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .HI_REG (HI_REG)
  ) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .wb_en       (bus.wb_en),
    .wb_addr     (bus.wb_addr),
    .wb_lower    (bus.wb_lower),
    .wb_upper_en (bus.wb_upper_en),
    .wb_upper    (bus.wb_upper),
    .wb_zero     (bus.wb_zero),
    .rs_addr     (bus.rs_addr),
    .rt_addr     (bus.rt_addr),
    .rd1         (rd1_s),
    .rd2         (rd2_s),
    .zero_flag   (zero_flag_s)
  );

`ifdef OPERAND_BYPASS_EN
  localparam logic [ADDR_W-1:0] HI_ADDR   = ADDR_W'(HI_REG);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic lo_we_s;

  // Forwarding: upper write to HI_REG has priority over a lower write there.
  always_comb begin
    lo_we_s = 1'b0;
    opnd1_s = rd1_s;
    opnd2_s = rd2_s;
    if (bus.wb_en && (bus.wb_addr != ZERO_ADDR) &&
        !(bus.wb_upper_en && (bus.wb_addr == HI_ADDR))) begin
      lo_we_s = 1'b1;
    end else begin
      lo_we_s = 1'b0;
    end
    if (bus.wb_upper_en && (bus.rs_addr == HI_ADDR)) begin
      opnd1_s = bus.wb_upper;
    end else if (lo_we_s && (bus.rs_addr == bus.wb_addr)) begin
      opnd1_s = bus.wb_lower;
    end else begin
      opnd1_s = rd1_s;
    end
    if (bus.wb_upper_en && (bus.rt_addr == HI_ADDR)) begin
      opnd2_s = bus.wb_upper;
    end else if (lo_we_s && (bus.rt_addr == bus.wb_addr)) begin
      opnd2_s = bus.wb_lower;
    end else begin
      opnd2_s = rd2_s;
    end
  end
`else
  // Read-first: operands are the stored contents before this edge's writes.
  always_comb begin
    opnd1_s = rd1_s;
    opnd2_s = rd2_s;
  end
`endif

  // Operand pipeline register; stall freezes every operand output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dat1_r     <= {DATA_W{1'b0}};
      dat2_r     <= {DATA_W{1'b0}};
      op_r       <= {OP_W{1'b0}};
      op_valid_r <= 1'b0;
    end else if (!bus.stall) begin
      dat1_r     <= opnd1_s;
      dat2_r     <= opnd2_s;
      op_r       <= bus.op_in;
      op_valid_r <= bus.rd_valid;
    end
  end

  assign bus.dat1      = dat1_r;
  assign bus.dat2      = dat2_r;
  assign bus.op        = op_r;
  assign bus.op_valid  = op_valid_r;
  assign bus.zero_flag = zero_flag_s;

endmodule

// File: doc/operand_regfile.md
Name: operand_regfile

Overview:
Operand-fetch stage sitting directly upstream of the 16-bit ALU.
- Holds a 16-entry x 16-bit register file.
- Reads two source registers and presents them, registered, as the ALU's data1/data2 operands, together with the 4-bit opcode and a valid flag.
- Accepts the ALU's writeback: lower result into a destination register, upper result into R15, zero result into a sticky status flag.

Parameters:
DATA_W, 16, register/operand width
ADDR_W, 4, register address width (2**ADDR_W entries)
HI_REG, 15, register index receiving the ALU upper result

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
rd_valid  input  1  operand-read request this cycle
stall  input  1  hold all operand outputs (downstream not ready)
rs_addr  input  ADDR_W  source-1 register index
rt_addr  input  ADDR_W  source-2 register index
op_in  input  4  opcode to forward with operands
dat1  output  DATA_W  registered operand 1 to ALU
dat2  output  DATA_W  registered operand 2 to ALU
op  output  4  registered opcode to ALU
op_valid  output  1  dat1/dat2/op are valid
wb_en  input  1  write lower result
wb_addr  input  ADDR_W  destination of lower result
wb_lower  input  DATA_W  ALU lower result
wb_upper_en  input  1  write upper result to HI_REG
wb_upper  input  DATA_W  ALU upper result
wb_zero  input  1  ALU zero result, captured when wb_en=1
zero_flag  output  1  last captured zero result

Behaviour:
- Reset (rst_n low, asynchronous): all 16 registers = 0; dat1 = dat2 = 0; op = 0; op_valid = 0; zero_flag = 0. Reset asserted mid-operation discards any pending read and all writes in that cycle.
- R0 is hard-wired zero: reads return 0; writes to R0 are dropped. wb_zero is still captured on a write to R0.
- Read latency is 1 cycle. On a rising edge with stall=0:
  - dat1 <= reg[rs_addr]; dat2 <= reg[rt_addr]; op <= op_in; op_valid <= rd_valid.
  - When rd_valid=0, dat1/dat2/op still update; only op_valid carries meaning.
- stall=1: dat1, dat2, op and op_valid hold their values. Register-file writes still occur.
- Write on the rising edge:
  - wb_en=1: reg[wb_addr] <= wb_lower; zero_flag <= wb_zero.
  - wb_upper_en=1: reg[HI_REG] <= wb_upper.
  - Both enabled with wb_addr == HI_REG: the upper write wins; the lower result is discarded.
  - wb_upper_en does not affect zero_flag.
- Read/write to the same address in the same cycle: see Optional Feature.
- Arithmetic: none; all data is stored and forwarded unmodified at DATA_W width.

Optional Feature:
Macro OPERAND_BYPASS_EN.
- Defined: write-first forwarding. If a read address equals an address being written this edge, the operand register captures the incoming write value (wb_upper for HI_REG under the upper-wins rule, else wb_lower). Read addresses of R0 still yield 0.
- Not defined: read-first. The operand captures the pre-write register contents, and the new value becomes visible on the next read.

Decomposition:
- Package operand_pkg: DATA_W/ADDR_W defaults, HI_REG constant, ZERO_REG = 0, opcode typedef (4-bit) shared with the ALU.
- One natural sub-module, regfile_core: storage array, write-priority logic, combinational read muxes.
- The top adds the operand pipeline register, stall hold and bypass.

Test Plan:
- Reset: drive rst_n low mid-stream after writes -> dat1 = dat2 = 0, op_valid = 0, zero_flag = 0; a subsequent read of R3 returns 0.
- Write then read: wb_en, wb_addr=3, wb_lower=16'h000F, then rd_valid with rs=3, rt=R0 -> next cycle dat1 = 16'h000F, dat2 = 16'h0000, op_valid = 1.
- Upper/lower conflict: wb_en, wb_addr=15, wb_lower=16'h1111, wb_upper_en, wb_upper=16'h2222 -> a read of R15 returns 16'h2222.
- Stall: load dat1 = 16'h0A00, then stall=1 for 3 cycles with changing rs_addr and a write to R5 -> dat1 stays 16'h0A00; after release, a read of R5 shows the written value.
- Same-cycle read/write of R4 (old 16'h00FF, new 16'hF0F0) -> dat1 = 16'hF0F0 with OPERAND_BYPASS_EN, 16'h00FF without.
- Zero flag: wb_en with wb_zero=1 -> zero_flag = 1; then wb_upper_en alone with wb_zero=0 -> zero_flag stays 1; then wb_en with wb_zero=0 -> zero_flag = 0.
